// File: rtl/vec_store_arbiter.sv
// vec_store_arbiter
//
// Round-robin arbiter that gives several vector-store requesters access to a
// single block-RAM write port. The winner's vector and base address are
// captured on the grant edge. The vector is then written one word per cycle at
// base+k. After the last word, a one-cycle done pulse goes to that requester.
//
// Ports
//   clk            rising-edge clock
//   RESET          synchronous, active-low reset
//   req            per-requester store request, held until that requester's done
//   reqAddr        per-requester base address, requester r at [r*memDepth +: memDepth]
//   reqData        per-requester vector, word k of requester r at
//                  [(r*NoOfElem+k)*wordSize +: wordSize]
//   grant          one-hot owner of the write port (registered)
//   done           one-cycle, one-hot completion pulse (registered)
//   dataOut        block-RAM write data (registered, holds while writeEN=0)
//   writeAddrBRAM  block-RAM write address (registered, holds while writeEN=0)
//   writeEN        block-RAM write enable (registered)
//   busy           high whenever the FSM is not in IDLE (registered)
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for (req & ~done); arbitrates round-robin from rr
// WRITE | emits buffer[k] at base+k, one word per edge, NoOfElem edges
// DONE  | drops writeEN and grant, pulses done[winner], advances rr

module vec_store_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int NoOfElem = 16,
    parameter int wordSize = 32,
    parameter int memDepth = 9
) (
    input  logic                                clk,
    input  logic                                RESET,
    input  logic [NUM_REQ-1:0]                  req,
    input  logic [NUM_REQ*memDepth-1:0]         reqAddr,
    input  logic [NUM_REQ*NoOfElem*wordSize-1:0] reqData,
    output logic [NUM_REQ-1:0]                  grant,
    output logic [NUM_REQ-1:0]                  done,
    output logic [wordSize-1:0]                 dataOut,
    output logic [memDepth-1:0]                 writeAddrBRAM,
    output logic                                writeEN,
    output logic                                busy
);

    localparam int RW = (NUM_REQ  > 1) ? $clog2(NUM_REQ)  : 1;
    localparam int KW = (NoOfElem > 1) ? $clog2(NoOfElem) : 1;
    localparam int VW = NoOfElem * wordSize;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    logic [RW-1:0]       rr;
    logic [RW-1:0]       winner;
    logic [KW-1:0]       k;
    logic [memDepth-1:0] base;
    logic [wordSize-1:0] buffer [NoOfElem];

    // Arbitration
    // A requester whose done is currently visible is masked so that a req
    // still held high in its done cycle is not granted a second time.
    logic [NUM_REQ-1:0]  pending;
    logic                win_found;
    logic [RW-1:0]       win_idx;
    logic [VW-1:0]       sel_data;
    logic [memDepth-1:0] sel_addr;

    always_comb begin
        logic [RW-1:0] idx;
        idx       = '0;
        pending   = req & ~done;
        win_found = 1'b0;
        win_idx   = '0;
        // NUM_REQ is a power of two, so rr+i wraps naturally in RW bits.
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = rr + RW'(i);
            if (!win_found && pending[idx]) begin
                win_found = 1'b1;
                win_idx   = idx;
            end
        end
    end

    always_comb begin
        sel_data = reqData[int'(win_idx)*VW +: VW];
        sel_addr = reqAddr[int'(win_idx)*memDepth +: memDepth];
    end

    // Vector capture
    // The buffer is not cleared by reset. It is always reloaded before use.
    always_ff @(posedge clk) begin
        if (RESET && (state == IDLE) && win_found) begin
            for (int j = 0; j < NoOfElem; j++) begin
                buffer[j] <= sel_data[j*wordSize +: wordSize];
            end
        end
    end

    // Control FSM
    always_ff @(posedge clk) begin
        if (!RESET) begin
            state         <= IDLE;
            rr            <= '0;
            winner        <= '0;
            k             <= '0;
            base          <= '0;
            grant         <= '0;
            done          <= '0;
            writeEN       <= 1'b0;
            dataOut       <= '0;
            writeAddrBRAM <= '0;
            busy          <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= '0;
                    if (win_found) begin
                        grant  <= NUM_REQ'(1) << win_idx;
                        winner <= win_idx;
                        base   <= sel_addr;
                        k      <= '0;
                        busy   <= 1'b1;
                        state  <= WRITE;
                    end
                end

                WRITE: begin
                    dataOut       <= buffer[k];
                    // Address arithmetic wraps modulo 2^memDepth.
                    writeAddrBRAM <= base + memDepth'(k);
                    writeEN       <= 1'b1;
                    k             <= k + KW'(1);
                    if (k == KW'(NoOfElem - 1)) begin
                        state <= DONE;
                    end
                end

                DONE: begin
                    writeEN <= 1'b0;
                    done    <= NUM_REQ'(1) << winner;
                    grant   <= '0;
                    rr      <= winner + RW'(1);
                    busy    <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_store_arbiter.sv
// Self-checking bench for vec_store_arbiter.
//
// The reference model describes each transfer as a timeline. A transfer starts
// on its arbitration edge n=0. Words are written on edges n=1..16. Done is
// signalled on edge n=17. The model's outputs are compared with the DUT on every
// falling edge. Directed tests also pin literal values: addresses, data,
// grant order and latency.

module tb_vec_store_arbiter;

    localparam int NR = 4;
    localparam int NE = 16;
    localparam int WS = 32;
    localparam int MD = 9;

    logic                   clk;
    logic                   RESET;
    logic [NR-1:0]          req;
    logic [NR*MD-1:0]       reqAddr;
    logic [NR*NE*WS-1:0]    reqData;
    logic [NR-1:0]          grant;
    logic [NR-1:0]          done;
    logic [WS-1:0]          dataOut;
    logic [MD-1:0]          writeAddrBRAM;
    logic                   writeEN;
    logic                   busy;

    vec_store_arbiter #(
        .NUM_REQ  (NR),
        .NoOfElem (NE),
        .wordSize (WS),
        .memDepth (MD)
    ) dut (
        .clk           (clk),
        .RESET         (RESET),
        .req           (req),
        .reqAddr       (reqAddr),
        .reqData       (reqData),
        .grant         (grant),
        .done          (done),
        .dataOut       (dataOut),
        .writeAddrBRAM (writeAddrBRAM),
        .writeEN       (writeEN),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model
    bit          m_active;
    int          m_n;
    int          m_w;
    int          m_rr;
    logic [8:0]  m_base;
    logic [31:0] m_data [NE];
    logic [3:0]  pend;
    bit          found;
    int          c;
    logic [3:0]  e_grant, e_done;
    logic        e_we, e_busy;
    logic [31:0] e_dout;
    logic [8:0]  e_addr;

    always @(posedge clk) begin
        cyc++;
        if (!RESET) begin
            m_active = 0; m_rr = 0; m_n = 0; m_w = 0;
            e_grant = 0; e_done = 0; e_we = 0; e_busy = 0; e_dout = 0; e_addr = 0;
        end else if (!m_active) begin
            pend   = req & ~e_done;
            e_done = 0;
            found  = 0;
            for (int i = 0; i < NR; i++) begin
                c = (m_rr + i) % NR;
                if (!found && pend[c]) begin
                    found = 1;
                    m_w = c;
                end
            end
            if (found) begin
                m_base = reqAddr[m_w*MD +: MD];
                for (int j = 0; j < NE; j++) m_data[j] = reqData[(m_w*NE+j)*WS +: WS];
                m_active = 1;
                m_n      = 0;
                e_grant  = 4'(1 << m_w);
                e_busy   = 1;
            end
        end else begin
            m_n++;
            if (m_n <= NE) begin
                e_we   = 1;
                e_dout = m_data[m_n-1];
                e_addr = 9'(m_base + 9'(m_n - 1));
            end else begin
                e_we     = 0;
                e_done   = 4'(1 << m_w);
                e_grant  = 0;
                e_busy   = 0;
                m_rr     = (m_w + 1) % NR;
                m_active = 0;
            end
        end
    end

    // Per-cycle compare and event logs
    int          wr_cyc [$];
    logic [8:0]  wr_addr [$];
    logic [31:0] wr_data [$];
    int          grant_w [$];
    int          grant_cyc [$];
    logic [3:0]  done_q [$];
    int          done_cyc [$];
    logic [3:0]  prev_grant = 0;

    always @(negedge clk) begin
        check("grant",   grant,         e_grant);
        check("done",    done,          e_done);
        check("writeEN", writeEN,       e_we);
        check("busy",    busy,          e_busy);
        check("dataOut", dataOut,       e_dout);
        check("wraddr",  writeAddrBRAM, e_addr);
        if (writeEN === 1'b1) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(writeAddrBRAM);
            wr_data.push_back(dataOut);
        end
        if (grant != 0 && prev_grant == 0) begin
            for (int i = 0; i < NR; i++) if (grant[i]) grant_w.push_back(i);
            grant_cyc.push_back(cyc);
        end
        if (done != 0) begin
            done_q.push_back(done);
            done_cyc.push_back(cyc);
        end
        prev_grant = grant;
    end

    // Stimulus helpers
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_cyc.delete(); wr_addr.delete(); wr_data.delete();
        grant_w.delete(); grant_cyc.delete(); done_q.delete(); done_cyc.delete();
    endtask

    task automatic load_req(input int r, input logic [8:0] a, input logic [31:0] d0, input logic [31:0] stp);
        reqAddr[r*MD +: MD] = a;
        for (int k = 0; k < NE; k++) reqData[(r*NE+k)*WS +: WS] = d0 + stp * k;
    endtask

    // Holds each req through the cycle its done is visible, then drops it.
    // If the bound expires, the count check below reports the failure.
    task automatic run_until(input int ndone, input int bound, input string name);
        logic [3:0] drop;
        drop = 0;
        for (int i = 0; i < bound && done_q.size() < ndone; i++) begin
            step();
            req  = req & ~drop;
            drop = done;
        end
        step();
        req = req & ~drop;
        check(name, done_q.size(), ndone);
    endtask

    task automatic do_reset(input int n);
        RESET = 1'b0;
        repeat (n) step();
        RESET = 1'b1;
        step();
    endtask

    initial begin
        int c0;
        RESET = 1'b0; req = 0; reqAddr = 0; reqData = 0;
        repeat (3) step();
        check("rst_grant", grant, 0);
        check("rst_we", writeEN, 0);
        check("rst_busy", busy, 0);
        check("rst_dout", dataOut, 0);
        RESET = 1'b1;
        step();

        // Single store from requester 2
        clear_logs();
        load_req(2, 9'h010, 32'hA0, 1);
        c0  = cyc;
        req = 4'b0100;
        run_until(1, 40, "t1_done_cnt");
        check("t1_latency", done_cyc[0] - c0, 18);
        check("t1_grant_lat", grant_cyc[0] - c0, 1);
        check("t1_winner", grant_w[0], 2);
        check("t1_done_val", done_q[0], 4'b0100);
        check("t1_nwr", wr_addr.size(), 16);
        check("t1_a0", wr_addr[0], 9'h010);
        check("t1_d0", wr_data[0], 32'hA0);
        check("t1_a15", wr_addr[15], 9'h01F);
        check("t1_d15", wr_data[15], 32'hAF);
        check("t1_first_we", wr_cyc[0] - grant_cyc[0], 1);
        repeat (3) step();
        check("t1_no_regrant", grant_w.size(), 1);

        // All four requesters at once after reset
        do_reset(2);
        clear_logs();
        for (int r = 0; r < NR; r++) load_req(r, 9'(32'h100 + r * 32'h20), 32'h1000 * r, 1);
        req = 4'hF;
        run_until(4, 120, "t2_done_cnt");
        check("t2_ngrants", grant_w.size(), 4);
        for (int r = 0; r < NR; r++) check("t2_order", grant_w[r], r);
        check("t2_nwr", wr_data.size(), 64);
        for (int j = 0; j < 64; j++) begin
            check("t2_data", wr_data[j], 32'h1000 * (j / 16) + (j % 16));
            check("t2_addr", wr_addr[j], 9'(32'h100 + (j / 16) * 32'h20 + (j % 16)));
            if (j > 0) check("t2_spacing", wr_cyc[j] - wr_cyc[j-1], (j % 16 == 0) ? 3 : 1);
        end

        // Address wrap
        clear_logs();
        load_req(1, 9'h1F8, 32'h300, 1);
        req = 4'b0010;
        run_until(1, 40, "t3_done_cnt");
        check("t3_a0", wr_addr[0], 9'h1F8);
        check("t3_a7", wr_addr[7], 9'h1FF);
        check("t3_a8", wr_addr[8], 9'h000);
        check("t3_a15", wr_addr[15], 9'h007);

        // Inputs corrupted and req dropped mid-transfer
        clear_logs();
        load_req(0, 9'h040, 32'h5000, 1);
        req = 4'b0001;
        for (int i = 0; i < 30 && wr_data.size() < 5; i++) step();
        check("t4_reach5", wr_data.size(), 5);
        load_req(0, 9'h100, 32'hDEAD0000, 3);
        req = 4'b0000;
        run_until(1, 40, "t4_done_cnt");
        check("t4_nwr", wr_data.size(), 16);
        for (int k = 0; k < NE; k++) begin
            check("t4_data", wr_data[k], 32'h5000 + k);
            check("t4_addr", wr_addr[k], 9'(32'h40 + k));
        end
        repeat (5) step();
        check("t4_no_regrant", grant_w.size(), 1);

        // Reset during write 7
        clear_logs();
        load_req(2, 9'h080, 32'h7000, 1);
        req = 4'b0100;
        for (int i = 0; i < 30 && wr_data.size() < 7; i++) step();
        check("t5_reach7", wr_data.size(), 7);
        RESET = 1'b0;
        req   = 4'b0000;
        step();
        check("t5_we_off", writeEN, 0);
        check("t5_busy_off", busy, 0);
        check("t5_grant_off", grant, 0);
        step();
        RESET = 1'b1;
        repeat (4) step();
        check("t5_no_done", done_q.size(), 0);
        check("t5_nwr", wr_data.size(), 7);
        clear_logs();
        load_req(3, 9'h0C0, 32'h8000, 1);
        req = 4'b1000;
        run_until(1, 40, "t5b_done_cnt");
        check("t5b_winner", grant_w[0], 3);
        check("t5b_done_val", done_q[0], 4'b1000);
        check("t5b_nwr", wr_data.size(), 16);
        check("t5b_a15", wr_addr[15], 9'h0CF);
        check("t5b_d15", wr_data[15], 32'h800F);

        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
